fetch_pc_unit: RTL and testbench

Instruction-fetch stage placed directly upstream of the byte-addressed, little-endian instruction memory in the single-cycle CPU.
- Holds the PC and drives the memory address.
- Passes the returned instruction word to decode.
- Computes the next PC: sequential, branch, jump or register target.
- Detects the halt opcode and out-of-range or misaligned fetches, and counts retired instructions.

---
 rtl/fetch_pc_unit_pkg.sv | 19 +
 rtl/fetch_pc_unit_next_pc_calc.sv | 46 ++++
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 tb/tb_fetch_pc_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// halt encodings and the fetch-state enumeration.
package fetch_pc_unit_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

    localparam logic [5:0]  DEFAULT_HALT_OPCODE = 6'b111111;
    localparam logic [31:0] HALT_WORD           = 32'hFC00_0000;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch,
// pseudo-direct jump or register target. All arithmetic wraps at 32 bits.
module next_pc_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] reg_target,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic [31:0] br_offset_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;

    // Candidate targets; the branch offset is in words, hence the shift by two.
    always_comb begin
        pc_plus4    = pc + 32'd4;
        br_offset_s = {{14{imm16[15]}}, imm16, 2'b00};
        br_target_s = pc_plus4 + br_offset_s;
        j_target_s  = {pc_plus4[31:28], jtarget, 2'b00};
    end

    // Select the candidate named by pc_src.
    always_comb begin
        npc = pc_plus4;
        case (pc_src)
            PC_SEQ: npc = pc_plus4;
            PC_BR: begin
                if (branch_taken) begin
                    npc = br_target_s;
                end else begin
                    npc = pc_plus4;
                end
            end
            PC_J:   npc = j_target_s;
            PC_REG: npc = reg_target;
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, halt/fault state machine, fetch-range
// check and retired-instruction counter in front of the instruction memory.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_LIMIT  = 64,
    parameter logic [5:0]  HALT_OPCODE = fetch_pc_unit_pkg::DEFAULT_HALT_OPCODE
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic        BranchTaken,
    input  logic [15:0] Imm16,
    input  logic [25:0] JTarget,
    input  logic [31:0] RegTarget,
    input  logic [31:0] InsIn,
    output logic [31:0] IAddr,
    output logic [31:0] Instr,
    output logic [31:0] PCPlus4,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] InsCount
);

    // Highest word-aligned address whose four bytes all lie inside memory.
    localparam logic [31:0] LAST_FETCH = 32'(IMEM_LIMIT - 32'd4);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  ins_count_r;
    logic [31:0]  ins_count_next_s;
    logic [31:0]  npc_s;
    logic [31:0]  pc_plus4_s;
    logic         is_halt_s;
    logic         npc_bad_s;

    next_pc_calc u_next_pc_calc (
        .pc           (pc_r),
        .pc_src       (PCSrc),
        .branch_taken (BranchTaken),
        .imm16        (Imm16),
        .jtarget      (JTarget),
        .reg_target   (RegTarget),
        .npc          (npc_s),
        .pc_plus4     (pc_plus4_s)
    );

    // Decode the halt opcode and range/alignment-check the candidate PC.
    always_comb begin
        is_halt_s = (InsIn[31:26] == HALT_OPCODE);
        npc_bad_s = (npc_s[1:0] != 2'b00) || (npc_s > LAST_FETCH);
    end

    // Next state, PC and counter; the faulting instruction still retires.
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        ins_count_next_s = ins_count_r;
        case (state_r)
            RUN: begin
                if (Stall) begin
                    state_next_s = RUN;
                end else if (is_halt_s) begin
                    state_next_s     = HALT;
                    ins_count_next_s = ins_count_r + 32'd1;
                end else if (npc_bad_s) begin
                    state_next_s     = FAULT;
                    ins_count_next_s = ins_count_r + 32'd1;
                end else begin
                    pc_next_s        = npc_s;
                    ins_count_next_s = ins_count_r + 32'd1;
                end
            end
            HALT:    state_next_s = HALT;
            FAULT:   state_next_s = FAULT;
            default: state_next_s = FAULT;
        endcase
    end

    // State, PC and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            ins_count_r <= 32'd0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            ins_count_r <= ins_count_next_s;
        end
    end

    // Outside RUN, decode sees the halt word so no later stage writes anything.
    always_comb begin
        if (state_r == RUN) begin
            Instr = InsIn;
        end else begin
            Instr = HALT_WORD;
        end
    end

    // Register-sourced status and address outputs.
    always_comb begin
        IAddr    = pc_r;
        PCPlus4  = pc_plus4_s;
        InsCount = ins_count_r;
        Halted   = (state_r == HALT);
        Fault    = (state_r == FAULT);
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: reset, sequential fetch,
// branches, stall, halt, fault boundaries, jump and counter wrap.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        Reset;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic        BranchTaken;
    logic [15:0] Imm16;
    logic [25:0] JTarget;
    logic [31:0] RegTarget;
    logic [31:0] InsIn;
    logic [31:0] IAddr;
    logic [31:0] Instr;
    logic [31:0] PCPlus4;
    logic        Halted;
    logic        Fault;
    logic [31:0] InsCount;

    int tests_run;
    int tests_failed;

    fetch_pc_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Stall       (Stall),
        .PCSrc       (PCSrc),
        .BranchTaken (BranchTaken),
        .Imm16       (Imm16),
        .JTarget     (JTarget),
        .RegTarget   (RegTarget),
        .InsIn       (InsIn),
        .IAddr       (IAddr),
        .Instr       (Instr),
        .PCPlus4     (PCPlus4),
        .Halted      (Halted),
        .Fault       (Fault),
        .InsCount    (InsCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Stall       = 1'b0;
        PCSrc       = 2'b00;
        BranchTaken = 1'b0;
        Imm16       = 16'h0000;
        JTarget     = 26'h0;
        RegTarget   = 32'h0;
        InsIn       = 32'h0000_0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        PCSrc     = 2'b11;
        RegTarget = target;
        step();
        PCSrc     = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        InsIn = 32'h0000_1234;
        #1;
        tests_run++;
        if (IAddr !== 32'h0 || Halted !== 1'b0 || Fault !== 1'b0 || InsCount !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: IAddr=%h Halted=%b Fault=%b InsCount=%0d, expected 0/0/0/0",
                     IAddr, Halted, Fault, InsCount);
        end
        tests_run++;
        if (Instr !== 32'h0000_1234 || PCPlus4 !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_passthru: Instr=%h PCPlus4=%h, expected 00001234/00000004", Instr, PCPlus4);
        end
        InsIn = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (IAddr !== 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL seq_step%0d: IAddr=%h, expected %h", i, IAddr, 32'(4 * i));
            end
        end
        tests_run++;
        if (InsCount !== 32'd3) begin
            tests_failed++;
            $display("FAIL seq_count: InsCount=%0d, expected 3", InsCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(32'd40);
        PCSrc = 2'b01; BranchTaken = 1'b1; Imm16 = 16'h0001;
        step();
        tests_run++;
        if (IAddr !== 32'd48) begin
            tests_failed++;
            $display("FAIL branch_fwd: IAddr=%0d, expected 48", IAddr);
        end
        PCSrc = 2'b00;
        step();
        PCSrc = 2'b01; BranchTaken = 1'b1; Imm16 = 16'hFFFE;
        step();
        tests_run++;
        if (IAddr !== 32'd48) begin
            tests_failed++;
            $display("FAIL branch_back: IAddr=%0d, expected 48", IAddr);
        end
        goto_pc(32'd52);
        PCSrc = 2'b01; BranchTaken = 1'b0; Imm16 = 16'hFFFE;
        step();
        tests_run++;
        if (IAddr !== 32'd56 || PCPlus4 !== 32'd60) begin
            tests_failed++;
            $display("FAIL branch_not_taken: IAddr=%0d PCPlus4=%0d, expected 56/60", IAddr, PCPlus4);
        end
        tests_run++;
        if (InsCount !== 32'd6) begin
            tests_failed++;
            $display("FAIL branch_count: InsCount=%0d, expected 6", InsCount);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        Stall = 1'b1;
        step();
        step();
        tests_run++;
        if (IAddr !== 32'd8 || InsCount !== 32'd2) begin
            tests_failed++;
            $display("FAIL stall_hold: IAddr=%0d InsCount=%0d, expected 8/2", IAddr, InsCount);
        end
        InsIn = 32'hFC00_0000;
        step();
        tests_run++;
        if (Halted !== 1'b0 || Instr !== 32'hFC00_0000 || IAddr !== 32'd8) begin
            tests_failed++;
            $display("FAIL stall_masks_halt: Halted=%b Instr=%h IAddr=%0d, expected 0/fc000000/8",
                     Halted, Instr, IAddr);
        end
        Stall = 1'b0;
        step();
        tests_run++;
        if (Halted !== 1'b1 || Fault !== 1'b0 || IAddr !== 32'd8 || InsCount !== 32'd3) begin
            tests_failed++;
            $display("FAIL stall_release_halt: Halted=%b Fault=%b IAddr=%0d InsCount=%0d, expected 1/0/8/3",
                     Halted, Fault, IAddr, InsCount);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        goto_pc(32'd56);
        InsIn = 32'hFC00_0000; PCSrc = 2'b10; JTarget = 26'h3;
        step();
        tests_run++;
        if (Halted !== 1'b1 || IAddr !== 32'd56 || InsCount !== 32'd2) begin
            tests_failed++;
            $display("FAIL halt_enter: Halted=%b IAddr=%0d InsCount=%0d, expected 1/56/2", Halted, IAddr, InsCount);
        end
        InsIn = 32'h1234_5678; PCSrc = 2'b11; RegTarget = 32'd8;
        step();
        step();
        tests_run++;
        if (Instr !== 32'hFC00_0000 || IAddr !== 32'd56 || InsCount !== 32'd2 || Halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_frozen: Instr=%h IAddr=%0d InsCount=%0d Halted=%b, expected fc000000/56/2/1",
                     Instr, IAddr, InsCount, Halted);
        end
        Stall = 1'b1;
        do_reset();
        tests_run++;
        if (IAddr !== 32'd0 || Halted !== 1'b0 || InsCount !== 32'd0) begin
            tests_failed++;
            $display("FAIL halt_reset: IAddr=%0d Halted=%b InsCount=%0d, expected 0/0/0", IAddr, Halted, InsCount);
        end
    endtask

    task automatic test_fault();
        do_reset();
        goto_pc(32'h6);
        InsIn = 32'h1234_5678;
        #1;
        tests_run++;
        if (Fault !== 1'b1 || Halted !== 1'b0 || IAddr !== 32'd0 || InsCount !== 32'd1 || Instr !== 32'hFC00_0000) begin
            tests_failed++;
            $display("FAIL fault_misaligned: Fault=%b Halted=%b IAddr=%0d InsCount=%0d Instr=%h, expected 1/0/0/1/fc000000",
                     Fault, Halted, IAddr, InsCount, Instr);
        end
        step();
        tests_run++;
        if (Fault !== 1'b1 || IAddr !== 32'd0 || InsCount !== 32'd1) begin
            tests_failed++;
            $display("FAIL fault_frozen: Fault=%b IAddr=%0d InsCount=%0d, expected 1/0/1", Fault, IAddr, InsCount);
        end
        do_reset();
        goto_pc(32'h44);
        tests_run++;
        if (Fault !== 1'b1 || IAddr !== 32'd0) begin
            tests_failed++;
            $display("FAIL fault_range: Fault=%b IAddr=%0d, expected 1/0", Fault, IAddr);
        end
        do_reset();
        goto_pc(32'h3C);
        tests_run++;
        if (Fault !== 1'b0 || IAddr !== 32'h3C) begin
            tests_failed++;
            $display("FAIL fault_last_legal: Fault=%b IAddr=%h, expected 0/0000003c", Fault, IAddr);
        end
        step();
        tests_run++;
        if (Fault !== 1'b1 || IAddr !== 32'h3C || InsCount !== 32'd2) begin
            tests_failed++;
            $display("FAIL fault_seq_overrun: Fault=%b IAddr=%h InsCount=%0d, expected 1/0000003c/2",
                     Fault, IAddr, InsCount);
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        do_reset();
        goto_pc(32'h10);
        PCSrc = 2'b10; JTarget = 26'h5;
        step();
        tests_run++;
        if (IAddr !== 32'h14 || Fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump: IAddr=%h Fault=%b, expected 00000014/0", IAddr, Fault);
        end
        idle_inputs();
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.ins_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.ins_count_r;
        #1;
        step();
        tests_run++;
        if (InsCount !== 32'h0 || IAddr !== 32'h4) begin
            tests_failed++;
            $display("FAIL count_wrap: InsCount=%h IAddr=%h, expected 00000000/00000004", InsCount, IAddr);
        end
        Stall = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        tests_run++;
        if (IAddr !== 32'h0 || InsCount !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: IAddr=%h InsCount=%h, expected 0/0", IAddr, InsCount);
        end
        Stall = 1'b0;
        step();
        tests_run++;
        if (IAddr !== 32'h4 || InsCount !== 32'h1) begin
            tests_failed++;
            $display("FAIL resume_after_reset: IAddr=%h InsCount=%h, expected 4/1", IAddr, InsCount);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b0;
        idle_inputs();
        test_reset();
        test_branch();
        test_stall();
        test_halt();
        test_fault();
        test_jump();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
